// File: rtl/exit_status_reporter.sv
`default_nettype none
// ============================================================================
// Module      : exit_status_reporter
// Description : APB slave that records the end-of-test result written by
//               software and drives done/status/code for the testbench
//               exit-status interface. Optional watchdog turns a hung
//               program into a TIMEOUT result; enable it by defining
//               EXIT_STATUS_WDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module exit_status_reporter #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int WDOG_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [APB_ADDR_WIDTH-1:0] paddr,
    input  logic [31:0]               pwdata,
    input  logic                      pwrite,
    input  logic                      psel,
    input  logic                      penable,
    output logic [31:0]               prdata,
    output logic                      pready,
    output logic                      pslverr,
    output logic                      done_o,
    output logic [1:0]                status_o,
    output logic [31:0]               exit_code_o
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ARMED  = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    localparam logic [1:0] c_STS_SUCCESS = 2'd1;
    localparam logic [1:0] c_STS_FAIL    = 2'd2;
    localparam logic [1:0] c_STS_TIMEOUT = 2'd3;

    localparam logic [1:0] c_REG_EXIT = 2'd0;
    localparam logic [1:0] c_REG_WDOG = 2'd1;
    localparam logic [1:0] c_REG_STAT = 2'd2;
    localparam logic [1:0] c_REG_KICK = 2'd3;

    logic [1:0] r_state;

    // Byte-lane bits of the address carry no meaning for word registers.
    logic w_unused;
    assign w_unused = &{1'b0, paddr[1:0]};

    logic       w_access;
    logic       w_unmapped;
    logic       w_wr;
    logic [1:0] w_sel;
    logic       w_wr_exit;

    assign w_access   = psel & penable;
    assign w_unmapped = |paddr[APB_ADDR_WIDTH-1:4];
    assign w_sel      = paddr[3:2];
    assign w_wr       = w_access & pwrite & ~w_unmapped;
    assign w_wr_exit  = w_wr & (w_sel == c_REG_EXIT);

    assign pready = 1'b1;

`ifdef EXIT_STATUS_WDOG_EN
    logic [WDOG_WIDTH-1:0] r_counter;
    logic [WDOG_WIDTH-1:0] r_wdog_load;
    logic                  w_wr_wdog;
    logic                  w_wr_kick;

    assign w_wr_wdog = w_wr & (w_sel == c_REG_WDOG);
    assign w_wr_kick = w_wr & (w_sel == c_REG_KICK);

    // Result FSM with watchdog; an EXIT write takes priority over everything,
    // and a KICK takes priority over the counter expiring.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            done_o      <= 1'b0;
            status_o    <= 2'd0;
            exit_code_o <= 32'd0;
            r_counter   <= '0;
            r_wdog_load <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_wr_exit) begin
                        r_state     <= c_ST_DONE;
                        done_o      <= 1'b1;
                        status_o    <= (pwdata == 32'd0) ? c_STS_SUCCESS : c_STS_FAIL;
                        exit_code_o <= pwdata;
                    end else if (w_wr_wdog) begin
                        r_counter   <= WDOG_WIDTH'(pwdata);
                        r_wdog_load <= WDOG_WIDTH'(pwdata);
                        if (WDOG_WIDTH'(pwdata) != '0) begin
                            r_state <= c_ST_ARMED;
                        end
                    end
                end
                c_ST_ARMED: begin
                    if (w_wr_exit) begin
                        r_state     <= c_ST_DONE;
                        done_o      <= 1'b1;
                        status_o    <= (pwdata == 32'd0) ? c_STS_SUCCESS : c_STS_FAIL;
                        exit_code_o <= pwdata;
                    end else if (w_wr_wdog) begin
                        r_counter   <= WDOG_WIDTH'(pwdata);
                        r_wdog_load <= WDOG_WIDTH'(pwdata);
                        if (WDOG_WIDTH'(pwdata) == '0) begin
                            r_state <= c_ST_IDLE;
                        end
                    end else if (w_wr_kick) begin
                        r_counter <= r_wdog_load;
                    end else if (r_counter <= WDOG_WIDTH'(1)) begin
                        r_counter   <= '0;
                        r_state     <= c_ST_DONE;
                        done_o      <= 1'b1;
                        status_o    <= c_STS_TIMEOUT;
                        exit_code_o <= 32'hFFFF_FFFF;
                    end else begin
                        r_counter <= r_counter - WDOG_WIDTH'(1);
                    end
                end
                default: begin
                    // Terminal: first result stays, counter frozen.
                    r_state <= c_ST_DONE;
                end
            endcase
        end
    end

    logic [31:0] w_rd_wdog;
    logic [31:0] w_rd_kick;
    assign w_rd_wdog = 32'(r_counter);
    assign w_rd_kick = 32'(r_wdog_load);
`else
    // Result FSM without watchdog: a single IDLE -> DONE transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            done_o      <= 1'b0;
            status_o    <= 2'd0;
            exit_code_o <= 32'd0;
        end else begin
            if ((r_state == c_ST_IDLE) && w_wr_exit) begin
                r_state     <= c_ST_DONE;
                done_o      <= 1'b1;
                status_o    <= (pwdata == 32'd0) ? c_STS_SUCCESS : c_STS_FAIL;
                exit_code_o <= pwdata;
            end
        end
    end

    logic [31:0] w_rd_wdog;
    logic [31:0] w_rd_kick;
    assign w_rd_wdog = 32'd0;
    assign w_rd_kick = 32'd0;
`endif

    // Read mux and error flag, live only during the access phase.
    always_comb begin
        prdata  = 32'd0;
        pslverr = 1'b0;
        if (w_access) begin
            if (w_unmapped) begin
                pslverr = 1'b1;
            end else if (!pwrite) begin
                case (w_sel)
                    c_REG_EXIT: prdata = exit_code_o;
                    c_REG_WDOG: prdata = w_rd_wdog;
                    c_REG_STAT: prdata = {29'd0, done_o, status_o};
                    c_REG_KICK: prdata = w_rd_kick;
                    default:    prdata = 32'd0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exit_status_reporter.sv
`default_nettype none
// ============================================================================
// Module      : tb_exit_status_reporter
// Description : Directed self-checking bench for exit_status_reporter.
//               Watchdog scenarios are compiled in with EXIT_STATUS_WDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exit_status_reporter;

    logic        clk;
    logic        rst_n;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        done_o;
    logic [1:0]  status_o;
    logic [31:0] exit_code_o;

    int n_checks = 0;
    int n_fail   = 0;

    exit_status_reporter #(
        .APB_ADDR_WIDTH (12),
        .WDOG_WIDTH     (32)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pwrite      (pwrite),
        .psel        (psel),
        .penable     (penable),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr),
        .done_o      (done_o),
        .status_o    (status_o),
        .exit_code_o (exit_code_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Write commits on the edge between the access negedge and the return negedge.
    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        #1 err = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk);
        penable = 1'b1;
        #1 d = prdata; err = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    // Count negedges until done_o is observed high, bounded.
    task automatic cycles_to_done(output int k);
        k = 0;
        while (!done_o && k < 60) begin
            @(negedge clk);
            k++;
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          k;

    initial begin
        rst_n = 1'b1; paddr = '0; pwdata = '0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0;

        // Reset state
        do_reset();
        #1;
        check_eq("rst_done",   32'(done_o), 32'd0);
        check_eq("rst_status", 32'(status_o), 32'd0);
        check_eq("rst_code",   exit_code_o, 32'd0);
        check_eq("pready",     32'(pready), 32'd1);
        check_eq("idle_prdata", prdata, 32'd0);
        check_eq("idle_pslverr", 32'(pslverr), 32'd0);
        apb_read(12'h008, rd, er);
        check_eq("stat_after_rst", rd, 32'd0);
        check_eq("stat_rd_err", 32'(er), 32'd0);
        apb_read(12'h00C, rd, er);
        check_eq("kick_rd_rst", rd, 32'd0);

        // Unmapped offset: error, no data, no state change
        apb_read(12'h010, rd, er);
        check_eq("unmap_rd_err", 32'(er), 32'd1);
        check_eq("unmap_rd_data", rd, 32'd0);
        apb_write(12'h010, 32'd0, er);
        check_eq("unmap_wr_err", 32'(er), 32'd1);
        check_eq("unmap_wr_nodone", 32'(done_o), 32'd0);
        apb_write(12'h800, 32'd0, er);
        check_eq("unmap_hi_wr_err", 32'(er), 32'd1);
        check_eq("unmap_hi_nodone", 32'(done_o), 32'd0);

        // STAT write ignored, no error
        apb_write(12'h008, 32'hFFFF_FFFF, er);
        check_eq("stat_wr_err", 32'(er), 32'd0);
        check_eq("stat_wr_nodone", 32'(done_o), 32'd0);

        // EXIT = 0 -> SUCCESS
        apb_write(12'h000, 32'd0, er);
        check_eq("exit0_err", 32'(er), 32'd0);
        check_eq("exit0_done", 32'(done_o), 32'd1);
        check_eq("exit0_status", 32'(status_o), 32'd1);
        check_eq("exit0_code", exit_code_o, 32'd0);
        apb_read(12'h008, rd, er);
        check_eq("exit0_stat_rd", rd, 32'd5);

        // Reset while DONE clears everything
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_done_clr", 32'(done_o), 32'd0);
        check_eq("rst_status_clr", 32'(status_o), 32'd0);
        check_eq("rst_code_clr", exit_code_o, 32'd0);
        rst_n = 1'b1;

        // FAIL result, first result wins
        apb_write(12'h000, 32'h0000_002A, er);
        check_eq("fail_status", 32'(status_o), 32'd2);
        check_eq("fail_code", exit_code_o, 32'h2A);
        apb_write(12'h000, 32'd0, er);
        check_eq("second_exit_err", 32'(er), 32'd0);
        check_eq("first_wins_status", 32'(status_o), 32'd2);
        check_eq("first_wins_code", exit_code_o, 32'h2A);
        apb_read(12'h000, rd, er);
        check_eq("exit_rd", rd, 32'h2A);
        apb_write(12'h004, 32'd4, er);
        check_eq("done_wdog_err", 32'(er), 32'd0);
        repeat (8) @(negedge clk);
        check_eq("done_hold_status", 32'(status_o), 32'd2);

`ifdef EXIT_STATUS_WDOG_EN
        // Timeout after exactly N cycles
        do_reset();
        apb_write(12'h004, 32'd10, er);
        check_eq("wdog_wr_err", 32'(er), 32'd0);
        cycles_to_done(k);
        check_eq("timeout_latency", 32'(k), 32'd10);
        check_eq("timeout_status", 32'(status_o), 32'd3);
        check_eq("timeout_code", exit_code_o, 32'hFFFF_FFFF);
        apb_read(12'h004, rd, er);
        check_eq("timeout_cnt", rd, 32'd0);
        apb_read(12'h00C, rd, er);
        check_eq("wdog_load_rd", rd, 32'd10);

        // Periodic kicks keep it alive
        do_reset();
        apb_write(12'h004, 32'd10, er);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            apb_write(12'h00C, 32'hDEAD_BEEF, er);
        end
        check_eq("kick_alive", 32'(done_o), 32'd0);
        apb_write(12'h000, 32'd0, er);
        check_eq("kick_exit_status", 32'(status_o), 32'd1);

        // EXIT on the same edge the counter reaches 0
        do_reset();
        apb_write(12'h004, 32'd3, er);
        apb_write(12'h000, 32'd7, er);
        check_eq("race_status", 32'(status_o), 32'd2);
        check_eq("race_code", exit_code_o, 32'd7);

        // KICK while counter holds 1 reloads instead of timing out
        do_reset();
        apb_write(12'h004, 32'd3, er);
        apb_write(12'h00C, 32'd0, er);
        check_eq("kick_race_done", 32'(done_o), 32'd0);
        cycles_to_done(k);
        check_eq("kick_race_latency", 32'(k), 32'd3);
        check_eq("kick_race_status", 32'(status_o), 32'd3);

        // WDOG write 0 disarms
        do_reset();
        apb_write(12'h004, 32'd5, er);
        apb_write(12'h004, 32'd0, er);
        repeat (10) @(negedge clk);
        check_eq("disarm_done", 32'(done_o), 32'd0);
`else
        // Watchdog absent: WDOG/KICK ignored
        do_reset();
        apb_write(12'h004, 32'd3, er);
        check_eq("nowdog_wr_err", 32'(er), 32'd0);
        repeat (10) @(negedge clk);
        check_eq("nowdog_done", 32'(done_o), 32'd0);
        apb_read(12'h004, rd, er);
        check_eq("nowdog_cnt_rd", rd, 32'd0);
        apb_read(12'h00C, rd, er);
        check_eq("nowdog_load_rd", rd, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
